fixedp_acc: RTL and testbench
=============================

# fixedp_acc

Sequential accumulator that consumes the stream of sign-magnitude fixed-point products from the fixed-point multiplier and sums a fixed-length (or early-terminated) vector of them into one saturated sign-magnitude result. It sits directly downstream of the multiplier in the detection datapath and forms the dot-product stage. Input and output use valid/ready handshakes, so upstream and downstream stages can stall it.

## Interface
- `Q`, default 15: fractional bits of input and output words.
- `N`, default 32: word width. MSB is the sign; the low N-1 bits are the magnitude.
- `LEN`, default 16: beats per accumulation. Legal range is 2..2^GUARD.
- `GUARD`, default 8: extra integer bits in the internal accumulator.

Ports:
- `clk`, in, 1: the only clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, N: sign-magnitude product.
- `in_valid`, in, 1: `in_data` is valid.
- `in_last`, in, 1: this beat ends the vector early. Sampled only on accepted beats.
- `in_ready`, out, 1: block can accept a beat.
- `out_data`, out, N: sign-magnitude sum.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_ovf`, out, 1: the result saturated. Present only with `FIXEDP_ACC_OVF_EN`.

## Operation
- States:
  - ACC: `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- Beat acceptance: a beat is accepted when `in_valid` and `in_ready` are both 1.
- Input conversion: each accepted word is converted to two's complement at width N+GUARD. The result is −mag when sign=1, +mag otherwise. A negative zero (`0x80000000` for N=32) equals 0.
- Accumulation: `acc` <= `acc` + converted. `cnt` increments on each accepted beat; its width is clog2(LEN).
- ACC→DONE: on an accepted beat with `cnt`==LEN-1 or `in_last`=1. The final beat is included in the result.
- Output registering: on that transition, `acc`+final is saturated to sign-magnitude and registered into `out_data`:
  - magnitude > 2^(N-1)-1 → magnitude = 2^(N-1)-1, overflow flag set;
  - the sign follows the sum;
  - a zero sum always outputs sign 0.
- DONE→ACC: on `out_valid` and `out_ready`. `acc` and `cnt` clear in the same edge.
- Hold in DONE: `out_data` (and `out_ovf`) stay stable while `out_valid`=1 and `out_ready`=0.
- No internal overflow: with LEN ≤ 2^GUARD, the internal accumulator cannot overflow. Only the output conversion saturates.
- `in_last` with `cnt`==LEN-1: both conditions identical; the vector terminates normally.

## Timing
- Reset values: state=ACC, `acc`=0, `cnt`=0, `out_data`=0, `out_valid`=0, `in_ready`=1, `out_ovf`=0.
- Reset mid-vector: discards partial sum and count. The first beat after release starts a new vector.
- Throughput: one beat per cycle in ACC.
- Latency: final beat accepted at edge t → `out_valid`=1 from t (visible cycle t+1).
- Output handshake: completes at edge t+k. `in_ready` returns to 1 after that edge. Next vector's first beat is accepted no earlier than edge t+k+1.
- Bubble: one bubble cycle per vector minimum (DONE always lasts ≥1 cycle).
- Ready independence: `in_ready` does not combinationally depend on `out_ready`. Both handshake outputs are registered state decodes.

## Configuration
- `FIXEDP_ACC_OVF_EN` defined: port `out_ovf` exists. It is registered with `out_data`, set when the output saturated, cleared on DONE→ACC and on reset.
- `FIXEDP_ACC_OVF_EN` undefined: port and flag logic absent. Saturation behaviour is unchanged.

## Test plan
All cases use N=32, Q=15, LEN=4, GUARD=8; 1.0 = `0x00008000`.
- Equal positives: 4 × `0x00008000`, `out_ready`=1 → `out_data`=`0x00020000` (4.0), `out_ovf`=0, `out_valid` high one cycle after the 4th beat.
- Mixed signs: `0x0000C000`, `0x80004000`, `0x80010000`, `0x00002000` (+1.5, −0.5, −2.0, +0.25) → `0x80006000` (−0.75).
- Cancellation and negative zero: `0x00008000`, `0x80008000`, `0x80000000`, `0x00000000` → `0x00000000` (sign 0).
- Positive saturation: 4 × `0x7FFFFFFF` → `0x7FFFFFFF`, `out_ovf`=1.
- Negative saturation: 4 × `0xFFFFFFFF` → `0xFFFFFFFF`, `out_ovf`=1.
- Early end and backpressure: beats `0x00008000`, then `0x00008000` with `in_last`=1, then `out_ready`=0 for 5 cycles while `in_valid`=1 → `out_data`=`0x00010000` held stable, `in_ready`=0 throughout. Raise `out_ready` → `in_ready`=1 next cycle, and the next vector's sum excludes prior beats.
- Reset mid-vector: 2 beats of `0x00008000`, pulse `rst_n` low → `out_valid`=0 and `in_ready`=1 immediately. Then 4 × `0x00004000` → `0x00010000`.

Source files
------------

// File: rtl/fixedp_acc.sv
// fixedp_acc: valid/ready accumulator that sums LEN (or in_last-terminated) sign-magnitude
// fixed-point products into one saturated sign-magnitude word. Optional out_ovf port via FIXEDP_ACC_OVF_EN.
module fixedp_acc #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int LEN   = 16,
  parameter int GUARD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef FIXEDP_ACC_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int AW = N + GUARD;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [AW-1:0] MAX_MAG = {{(GUARD + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  // Q only sets the binary-point position; the datapath is scale-agnostic.
  if (LEN < 2 || LEN > (1 << GUARD) || Q < 0 || Q > N - 1) begin : g_param_check
    $error("fixedp_acc: illegal parameter combination");
  end

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] in_ext;
  logic [AW-1:0] in_conv;
  logic [AW-1:0] sum;
  logic [AW-1:0] sum_abs;
  logic          sum_neg;
  logic          sat;
  logic [N-2:0]  res_mag;
  logic [N-1:0]  res_word;
  logic          accept;
  logic          final_beat;
  logic          release_out;

  // Negative zero converts to 0 naturally: -(0) == 0 in two's complement.
  always_comb begin
    in_ext  = {{(GUARD + 1){1'b0}}, in_data[N-2:0]};
    in_conv = in_data[N-1] ? (~in_ext + 1'b1) : in_ext;
    sum     = acc + in_conv;
    sum_neg = sum[AW-1];
    sum_abs = sum_neg ? (~sum + 1'b1) : sum;
    sat     = (sum_abs > MAX_MAG);
    res_mag = sat ? MAX_MAG[N-2:0] : sum_abs[N-2:0];
    // A zero sum has sum_neg == 0, so the sign bit is never set for zero.
    res_word = {sum_neg, res_mag};
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    state_next  = state;
    accept      = 1'b0;
    final_beat  = 1'b0;
    release_out = 1'b0;
    unique case (state)
      ACC: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        final_beat = in_valid && (in_last || (cnt == CNT_LAST));
        if (final_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid   = 1'b1;
        release_out = out_ready;
        if (out_ready) begin
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (release_out) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (final_beat) begin
      out_data <= res_word;
    end
  end

`ifdef FIXEDP_ACC_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (final_beat) begin
      out_ovf <= sat;
    end else if (release_out) begin
      out_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fixedp_acc.sv
// Directed self-checking bench for fixedp_acc (N=32, Q=15, LEN=4, GUARD=8); 1.0 = 0x00008000.
module tb_fixedp_acc;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef FIXEDP_ACC_OVF_EN
  logic        out_ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  fixedp_acc #(.Q(15), .N(32), .LEN(4), .GUARD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIXEDP_ACC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef FIXEDP_ACC_OVF_EN
    chk(tag, {31'b0, out_ovf}, {31'b0, exp});
`else
    if (exp === 1'bx) $write("");
    if (tag.len() == 0) $write("");
`endif
  endtask

  // Called at posedge+1; presents one beat, checks it will be accepted, advances one edge.
  task automatic beat(input string tag, input logic [31:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic vec4(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3,
                      input logic [31:0] exp, input logic exp_ovf);
    beat(tag, d0, 1'b0);
    beat(tag, d1, 1'b0);
    beat(tag, d2, 1'b0);
    chk({tag, "_no_early_valid"}, {31'b0, out_valid}, 32'd0);
    beat(tag, d3, 1'b0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_in_ready_low"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_out_data"}, out_data, exp);
    chk_ovf({tag, "_ovf"}, exp_ovf);
    @(posedge clk);
    #1;
    chk({tag, "_released"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    chk_ovf({tag, "_ovf_clr"}, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'h0);
    chk_ovf("rst_ovf", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vec4("equal_pos", 32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000, 32'h00020000, 1'b0);
    vec4("mixed", 32'h0000C000, 32'h80004000, 32'h80010000, 32'h00002000, 32'h80006000, 1'b0);
    vec4("cancel", 32'h00008000, 32'h80008000, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    vec4("pos_sat", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
    vec4("neg_sat", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    vec4("one_neg", 32'h80008000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80008000, 1'b0);

    // Early termination followed by backpressure while upstream keeps offering a beat.
    beat("early", 32'h00008000, 1'b0);
    out_ready = 1'b0;
    beat("early", 32'h00008000, 1'b1);
    in_data  = 32'h00FF0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_data", out_data, 32'h00010000);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    chk("bp_valid_drop", {31'b0, out_valid}, 32'd0);
    vec4("after_bp", 32'h00002000, 32'h00002000, 32'h00002000, 32'h00002000, 32'h00008000, 1'b0);

    // Reset in the middle of a vector throws away the partial sum.
    beat("mid", 32'h00008000, 1'b0);
    beat("mid", 32'h00008000, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vec4("post_rst", 32'h00004000, 32'h00004000, 32'h00004000, 32'h00004000, 32'h00010000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
